// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the initiator state type for ahb_mst.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_INCR4  = 3'b011,
      HBURST_INCR8  = 3'b101,
      HBURST_INCR16 = 3'b111
   } hburst_t;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA_LAST,
      ST_ERR
   } mst_state_t;

   // Fixed-length encodings only for 1/4/8/16 beats; everything else is INCR.
   function automatic hburst_t burst_enc(input int unsigned len);
      hburst_t b;
      case (len)
         1:       b = HBURST_SINGLE;
         4:       b = HBURST_INCR4;
         8:       b = HBURST_INCR8;
         16:      b = HBURST_INCR16;
         default: b = HBURST_INCR;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ahb_mst.sv
// ahb_mst: AHB-Lite initiator issuing one pipelined word-sized burst per command.
// Optional: define AHB_MST_1KB_SPLIT_EN to restart a burst as NONSEQ/INCR at 1 KB crossings.
module ahb_mst
   import ahb_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              done_err,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   mst_state_t        state_q, state_d;
   htrans_t           htrans_q, htrans_d;
   hburst_t           hburst_q, hburst_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              done_q, done_d;
   logic              done_err_q, done_err_d;
   logic [LEN_W-1:0]  beats_q, beats_d;
   logic              dpend_q, dpend_d;   // a data phase is in progress this cycle
   logic [LEN_W-1:0]  len_eff;
   logic [ADDR_W-1:0] nxt_addr;
   logic              err_first;

   assign len_eff   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
   assign nxt_addr  = haddr_q + ADDR_W'(4);
   assign err_first = hresp & ~hready;

   assign cmd_ready = (state_q == ST_IDLE);
   assign haddr     = haddr_q;
   assign htrans    = htrans_q;
   assign hwrite    = hwrite_q;
   assign hsize     = HSIZE_WORD;
   assign hburst    = hburst_q;
   assign hwdata    = hwdata_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign done_err  = done_err_q;

   // Next-state, bus control and beat bookkeeping.
   // wr_pop is combinational so the source advances on the same edge that loads hwdata.
   always_comb begin
      state_d    = state_q;
      htrans_d   = htrans_q;
      hburst_d   = hburst_q;
      haddr_d    = haddr_q;
      hwrite_d   = hwrite_q;
      hwdata_d   = hwdata_q;
      rd_data_d  = rd_data_q;
      beats_d    = beats_q;
      dpend_d    = dpend_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      done_err_d = 1'b0;
      wr_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               htrans_d = HTRANS_NONSEQ;
               haddr_d  = cmd_addr;
               hwrite_d = cmd_write;
               hburst_d = burst_enc(32'(len_eff));
               beats_d  = len_eff;
               dpend_d  = 1'b0;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (err_first) begin
               htrans_d = HTRANS_IDLE;
               state_d  = ST_ERR;
            end else if (hready) begin
               if (dpend_q && !hwrite_q && !hresp) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = hrdata;
               end
               if (hwrite_q) begin
                  wr_pop   = 1'b1;
                  hwdata_d = wr_data;
               end
               dpend_d = 1'b1;
               if (beats_q > LEN_W'(1)) begin
                  beats_d  = beats_q - LEN_W'(1);
                  haddr_d  = nxt_addr;
                  htrans_d = HTRANS_SEQ;
`ifdef AHB_MST_1KB_SPLIT_EN
                  if (nxt_addr[9:0] == '0) begin
                     htrans_d = HTRANS_NONSEQ;
                     hburst_d = HBURST_INCR;
                  end
`endif
               end else begin
                  htrans_d = HTRANS_IDLE;
                  state_d  = ST_DATA_LAST;
               end
            end
         end
         ST_DATA_LAST: begin
            if (err_first) begin
               htrans_d = HTRANS_IDLE;
               state_d  = ST_ERR;
            end else if (hready) begin
               if (!hwrite_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = hrdata;
               end
               done_d  = 1'b1;
               dpend_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (hready) begin
               done_d     = 1'b1;
               done_err_d = 1'b1;
               dpend_d    = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with asynchronous abort to idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         htrans_q   <= HTRANS_IDLE;
         hburst_q   <= HBURST_SINGLE;
         haddr_q    <= '0;
         hwrite_q   <= 1'b0;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
         beats_q    <= '0;
         dpend_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         htrans_q   <= htrans_d;
         hburst_q   <= hburst_d;
         haddr_q    <= haddr_d;
         hwrite_q   <= hwrite_d;
         hwdata_q   <= hwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         done_err_q <= done_err_d;
         beats_q    <= beats_d;
         dpend_q    <= dpend_d;
      end
   end

endmodule

// File: tb/tb_ahb_mst.sv
// tb_ahb_mst: directed self-checking bench for ahb_mst.
module tb_ahb_mst;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [4:0]  cmd_len;
   logic [31:0] wr_data, rd_data, haddr, hwdata, hrdata;
   logic        wr_pop, rd_valid, done, done_err, hwrite, hready, hresp;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;

   int tests_run = 0;
   int tests_failed = 0;

   // write-data source model and event counters
   logic [31:0] wsrc [0:63];
   int          wr_idx = 0;
   logic        pop_seen = 1'b0;
   int          pop_cnt = 0;
   int          rd_cnt = 0;
   int          done_cnt = 0;

   assign wr_data = wsrc[wr_idx % 64];

   ahb_mst #(.MAX_LEN(16), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .done_err(done_err),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 clk = ~clk;

   // observe strobes mid-cycle
   always @(negedge clk) begin
      pop_seen <= wr_pop;
      if (wr_pop)   pop_cnt  <= pop_cnt + 1;
      if (rd_valid) rd_cnt   <= rd_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   // source advances on the edge where the pop is taken
   always @(posedge clk) begin
      if (pop_seen) wr_idx <= wr_idx + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [88:0] got;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      hrdata = '0; hready = 1'b1; hresp = 1'b0;
      for (int i = 0; i < 64; i++) wsrc[i] = '0;
      #12;
      got = {htrans, haddr, hwrite, hburst, wr_pop, rd_valid, done, done_err, cmd_ready, hsize, hwdata[7:0], rd_data[7:0]};
      tests_run++;
      if (got !== {2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 8'h00}) begin
         tests_failed++;
         $display("FAIL reset_values: got %h expected %h", got,
                  {2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 8'h00});
      end
      tests_run++;
      if ({hwdata, rd_data} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", {hwdata, rd_data});
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_read_single();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA000_0010; cmd_len = 5'd1;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h1234_5678;
      tick();
      cmd_valid = 1'b0;
      tests_run++;
      if ({htrans, haddr, hburst, hwrite, cmd_ready} !== {2'b10, 32'hA000_0010, 3'b000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rs_addr_phase: got %h expected %h", {htrans, haddr, hburst, hwrite, cmd_ready},
                  {2'b10, 32'hA000_0010, 3'b000, 1'b0, 1'b0});
      end
      tick();
      tests_run++;
      if ({htrans, rd_valid} !== {2'b00, 1'b0}) begin
         tests_failed++;
         $display("FAIL rs_data_phase: got %h expected 0", {htrans, rd_valid});
      end
      tick();
      tests_run++;
      if ({rd_valid, rd_data, done, done_err} !== {1'b1, 32'h1234_5678, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL rs_result: got %h expected %h", {rd_valid, rd_data, done, done_err},
                  {1'b1, 32'h1234_5678, 1'b1, 1'b0});
      end
      tick();
      tests_run++;
      if ({rd_valid, done, cmd_ready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL rs_after: got %b expected 001", {rd_valid, done, cmd_ready});
      end
   endtask

   task automatic test_write_incr4();
      int p0;
      logic [1:0] exp_t;
      for (int k = 0; k < 4; k++) wsrc[(wr_idx + k) % 64] = 32'h11 * (k + 1);
      p0 = pop_cnt;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hB000_0000; cmd_len = 5'd4;
      hready = 1'b1; hresp = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_t = (k == 0) ? 2'b10 : 2'b11;
         tests_run++;
         if ({htrans, haddr, hburst, hwrite, wr_pop} !== {exp_t, 32'hB000_0000 + 32'(4 * k), 3'b011, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL w4_beat%0d: got %h expected %h", k, {htrans, haddr, hburst, hwrite, wr_pop},
                     {exp_t, 32'hB000_0000 + 32'(4 * k), 3'b011, 1'b1, 1'b1});
         end
         if (k > 0) begin
            tests_run++;
            if (hwdata !== 32'h11 * k) begin
               tests_failed++;
               $display("FAIL w4_hwdata%0d: got %h expected %h", k, hwdata, 32'h11 * k);
            end
         end
         tick();
      end
      tests_run++;
      if ({htrans, hwdata, wr_pop, done} !== {2'b00, 32'h44, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL w4_last_data: got %h expected %h", {htrans, hwdata, wr_pop, done}, {2'b00, 32'h44, 1'b0, 1'b0});
      end
      tick();
      tests_run++;
      if ({done, done_err, rd_valid} !== 3'b100) begin
         tests_failed++;
         $display("FAIL w4_done: got %b expected 100", {done, done_err, rd_valid});
      end
      tests_run++;
      if (pop_cnt - p0 !== 4) begin
         tests_failed++;
         $display("FAIL w4_pops: got %0d expected 4", pop_cnt - p0);
      end
      tick();
   endtask

   task automatic test_read_wait();
      int r0;
      r0 = rd_cnt;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA000_0100; cmd_len = 5'd3;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      tick();
      cmd_valid = 1'b0;
      tests_run++;
      if ({htrans, haddr, hburst} !== {2'b10, 32'hA000_0100, 3'b001}) begin
         tests_failed++;
         $display("FAIL rw_beat0: got %h expected %h", {htrans, haddr, hburst}, {2'b10, 32'hA000_0100, 3'b001});
      end
      tick();
      tests_run++;
      if ({htrans, haddr} !== {2'b11, 32'hA000_0104}) begin
         tests_failed++;
         $display("FAIL rw_beat1: got %h expected %h", {htrans, haddr}, {2'b11, 32'hA000_0104});
      end
      hrdata = 32'hD000_0001;
      tick();
      tests_run++;
      if ({htrans, haddr, rd_valid, rd_data} !== {2'b11, 32'hA000_0108, 1'b1, 32'hD000_0001}) begin
         tests_failed++;
         $display("FAIL rw_beat2_rd0: got %h expected %h", {htrans, haddr, rd_valid, rd_data},
                  {2'b11, 32'hA000_0108, 1'b1, 32'hD000_0001});
      end
      hready = 1'b0; hrdata = 32'hDEAD_BEEF;
      for (int w = 0; w < 2; w++) begin
         tick();
         tests_run++;
         if ({htrans, haddr, rd_valid} !== {2'b11, 32'hA000_0108, 1'b0}) begin
            tests_failed++;
            $display("FAIL rw_hold%0d: got %h expected %h", w, {htrans, haddr, rd_valid}, {2'b11, 32'hA000_0108, 1'b0});
         end
         if (w == 1) begin
            hready = 1'b1; hrdata = 32'hD000_0002;
         end
      end
      tick();
      tests_run++;
      if ({htrans, rd_valid, rd_data} !== {2'b00, 1'b1, 32'hD000_0002}) begin
         tests_failed++;
         $display("FAIL rw_rd1: got %h expected %h", {htrans, rd_valid, rd_data}, {2'b00, 1'b1, 32'hD000_0002});
      end
      hrdata = 32'hD000_0003;
      tick();
      tests_run++;
      if ({rd_valid, rd_data, done, done_err} !== {1'b1, 32'hD000_0003, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL rw_rd2_done: got %h expected %h", {rd_valid, rd_data, done, done_err},
                  {1'b1, 32'hD000_0003, 1'b1, 1'b0});
      end
      tick();
      tests_run++;
      if (rd_cnt - r0 !== 3) begin
         tests_failed++;
         $display("FAIL rw_count: got %0d expected 3", rd_cnt - r0);
      end
   endtask

   // ERROR response arrives in the data phase of beat index 3 (the fourth beat),
   // while beat index 4's address phase is on the bus and gets cancelled.
   task automatic test_write_error();
      int p0;
      for (int k = 0; k < 8; k++) wsrc[(wr_idx + k) % 64] = 32'h100 + k;
      p0 = pop_cnt;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hB000_0000; cmd_len = 5'd8;
      hready = 1'b1; hresp = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tests_run++;
      if (hburst !== 3'b101) begin
         tests_failed++;
         $display("FAIL we_hburst: got %b expected 101", hburst);
      end
      for (int k = 0; k < 4; k++) tick();
      tests_run++;
      if ({htrans, haddr} !== {2'b11, 32'hB000_0010}) begin
         tests_failed++;
         $display("FAIL we_beat4: got %h expected %h", {htrans, haddr}, {2'b11, 32'hB000_0010});
      end
      hready = 1'b0; hresp = 1'b1;
      #1;
      tests_run++;
      if (wr_pop !== 1'b0) begin
         tests_failed++;
         $display("FAIL we_pop_err1: got %b expected 0", wr_pop);
      end
      tick();
      hready = 1'b1; hresp = 1'b1;
      #1;
      tests_run++;
      if ({htrans, wr_pop, done, hwdata} !== {2'b00, 1'b0, 1'b0, 32'h103}) begin
         tests_failed++;
         $display("FAIL we_cancel: got %h expected %h", {htrans, wr_pop, done, hwdata}, {2'b00, 1'b0, 1'b0, 32'h103});
      end
      tick();
      hresp = 1'b0;
      tests_run++;
      if ({done, done_err} !== 2'b11) begin
         tests_failed++;
         $display("FAIL we_done_err: got %b expected 11", {done, done_err});
      end
      tick();
      tests_run++;
      if ({cmd_ready, done, htrans} !== {1'b1, 1'b0, 2'b00}) begin
         tests_failed++;
         $display("FAIL we_after: got %b expected 1000", {cmd_ready, done, htrans});
      end
      tests_run++;
      if (pop_cnt - p0 !== 4) begin
         tests_failed++;
         $display("FAIL we_pops: got %0d expected 4", pop_cnt - p0);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC000_0000; cmd_len = 5'd16;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0000_0077;
      tick();
      cmd_valid = 1'b0;
      tests_run++;
      if (hburst !== 3'b111) begin
         tests_failed++;
         $display("FAIL rm_hburst: got %b expected 111", hburst);
      end
      for (int k = 0; k < 4; k++) tick();
      d0 = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({htrans, haddr, hwrite, hburst, wr_pop, rd_valid, rd_data, done, done_err, cmd_ready} !==
          {2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL rm_async: got %h expected %h",
                  {htrans, haddr, hwrite, hburst, wr_pop, rd_valid, rd_data, done, done_err, cmd_ready},
                  {2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tests_run++;
      if (done_cnt - d0 !== 0) begin
         tests_failed++;
         $display("FAIL rm_no_done: got %0d expected 0", done_cnt - d0);
      end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA000_0020; cmd_len = 5'd0;
      hrdata = 32'h0000_55AA;
      tick();
      cmd_valid = 1'b0;
      tests_run++;
      if ({htrans, haddr, hburst} !== {2'b10, 32'hA000_0020, 3'b000}) begin
         tests_failed++;
         $display("FAIL rm_new_cmd: got %h expected %h", {htrans, haddr, hburst}, {2'b10, 32'hA000_0020, 3'b000});
      end
      tick();
      tick();
      tests_run++;
      if ({rd_valid, rd_data, done} !== {1'b1, 32'h0000_55AA, 1'b1}) begin
         tests_failed++;
         $display("FAIL rm_new_done: got %h expected %h", {rd_valid, rd_data, done}, {1'b1, 32'h0000_55AA, 1'b1});
      end
      tick();
   endtask

   task automatic test_split();
      logic [1:0] exp_t;
      logic [2:0] exp_b;
`ifdef AHB_MST_1KB_SPLIT_EN
      exp_t = 2'b10; exp_b = 3'b001;
`else
      exp_t = 2'b11; exp_b = 3'b011;
`endif
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA000_03F8; cmd_len = 5'd4;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      tick();
      cmd_valid = 1'b0;
      tick();
      tests_run++;
      if ({htrans, haddr, hburst} !== {2'b11, 32'hA000_03FC, 3'b011}) begin
         tests_failed++;
         $display("FAIL sp_beat1: got %h expected %h", {htrans, haddr, hburst}, {2'b11, 32'hA000_03FC, 3'b011});
      end
      tick();
      tests_run++;
      if ({htrans, haddr, hburst} !== {exp_t, 32'hA000_0400, exp_b}) begin
         tests_failed++;
         $display("FAIL sp_cross: got %h expected %h", {htrans, haddr, hburst}, {exp_t, 32'hA000_0400, exp_b});
      end
      tick();
      tests_run++;
      if ({htrans, haddr} !== {2'b11, 32'hA000_0404}) begin
         tests_failed++;
         $display("FAIL sp_beat3: got %h expected %h", {htrans, haddr}, {2'b11, 32'hA000_0404});
      end
      tick();
      tick();
      tests_run++;
      if ({done, done_err} !== 2'b10) begin
         tests_failed++;
         $display("FAIL sp_done: got %b expected 10", {done, done_err});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_read_single();
      test_write_incr4();
      test_read_wait();
      test_write_error();
      test_reset_mid();
      test_split();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
